cla_serial_add_ctrl: RTL and testbench

Multi-cycle 16-bit add/subtract unit that time-shares a single `cla_4bit` slice across four nibble steps, least-significant nibble first, carrying between steps in a register. It sits beside the ALU as the area-reduced arithmetic path and uses a start/busy/done handshake toward its requester. Results and flags are held after completion until the next accepted start.

---
 rtl/cla_serial_add_ctrl_pkg.sv | 14 +
 rtl/cla_4bit.sv | 35 +++
 rtl/cla_serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared definitions for the serial nibble-wide add/subtract unit:
// controller states, slice width and the default operand width.
package cla_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/cla_4bit.sv
// Four-bit carry-lookahead adder slice. Carries are formed directly from
// generate/propagate terms so the slice is a single flat level of logic.
// ovfl is the signed overflow of this slice taken as the top of a word:
// carry into the MSB differs from carry out of it.
module cla_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout,
  output logic       ovfl
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] carry;

  // Lookahead carries expanded from the generate/propagate terms.
  always_comb begin
    gen      = A & B;
    prop     = A ^ B;
    carry[0] = Cin;
    carry[1] = gen[0] | (prop[0] & Cin);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & Cin);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & Cin);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & Cin);
    S        = prop ^ carry[3:0];
    Cout     = carry[4];
    ovfl     = carry[3] ^ carry[4];
  end

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Area-reduced 16-bit add/subtract: one cla_4bit slice is reused across
// the nibbles, least significant first, with the inter-nibble carry held
// in a register. Subtraction is A + ~B + 1, the +1 entering as the
// initial carry. Results and flags hold until the next accepted start.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovfl,
  output logic             Zero
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_q;
  logic [WIDTH-1:0]    opA_q;
  logic [WIDTH-1:0]    opB_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                ovfl_q;
  logic                zero_q;

  logic [WIDTH-1:0]    sum_d;
  logic [NIBBLE_W-1:0] sliceA;
  logic [NIBBLE_W-1:0] sliceB;
  logic [NIBBLE_W-1:0] sliceS;
  logic                sliceCout;
  logic                sliceOvfl;

  // Select the operand nibbles for the current step and merge the slice
  // result into the running sum, so the last step can test the full word.
  always_comb begin
    sliceA = '0;
    sliceB = '0;
    sum_d  = sum_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == n[IDX_W-1:0]) begin
        sliceA                        = opA_q[n*NIBBLE_W +: NIBBLE_W];
        sliceB                        = opB_q[n*NIBBLE_W +: NIBBLE_W];
        sum_d[n*NIBBLE_W +: NIBBLE_W] = sliceS;
      end
    end
  end

  cla_4bit slice_u (
    .A    (sliceA),
    .B    (sliceB),
    .Cin  (carry_q),
    .S    (sliceS),
    .Cout (sliceCout),
    .ovfl (sliceOvfl)
  );

  // Controller: accept in IDLE/DONE, one nibble per RUN cycle, one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            opA_q   <= A;
            opB_q   <= sub ? ~B : B;
            carry_q <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= sliceCout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= sliceCout;
            ovfl_q  <= sliceOvfl;
            zero_q  <= (sum_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovfl = ovfl_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Self-checking bench for cla_serial_add_ctrl: directed corner cases,
// handshake/abort scenarios and randomized operations compared against
// an integer-arithmetic reference model.
module tb_cla_serial_add_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovfl;
  logic         Zero;

  int assertCount;
  int failCount;

  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovfl  (Ovfl),
    .Zero  (Zero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] expSum, output logic expCout,
                          output logic expOvfl, output logic expZero);
    int ua, ub, sa, sb, ures, sres;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (s) begin
      ures    = ua - ub;
      sres    = sa - sb;
      expCout = (ua >= ub);
    end else begin
      ures    = ua + ub;
      sres    = sa + sb;
      expCout = (ures >= 65536);
    end
    expSum  = W'(ures);
    expOvfl = (sres > 32767) || (sres < -32768);
    expZero = (expSum == '0);
  endtask

  // Present an operation for one cycle; returns in the first RUN cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1;
    A     = a;
    B     = b;
    sub   = s;
    tick();
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    sub   = 1'($urandom);
  endtask

  // Walk RUN cycles 1..4 checking the handshake, then check the DONE cycle.
  // With noisy set, start is pulsed with fresh operands during RUN.
  task automatic finishOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit noisy);
    logic [W-1:0] eSum;
    logic         eC, eV, eZ;
    refModel(a, b, s, eSum, eC, eV, eZ);
    for (int i = 1; i <= 4; i++) begin
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".doneInRun"}, 32'(done), 32'd0);
      if (noisy && (i == 2 || i == 3)) begin
        start = 1'b1;
        A     = W'($urandom);
        B     = W'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".busyInDone"}, 32'(busy), 32'd0);
    checkOutput({tag, ".Sum"}, 32'(Sum), 32'(eSum));
    checkOutput({tag, ".Cout"}, 32'(Cout), 32'(eC));
    checkOutput({tag, ".Ovfl"}, 32'(Ovfl), 32'(eV));
    checkOutput({tag, ".Zero"}, 32'(Zero), 32'(eZ));
  endtask

  // Leave DONE with start low and confirm the pulse ends and results hold.
  task automatic idleAfter(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
    logic [W-1:0] eSum;
    logic         eC, eV, eZ;
    refModel(a, b, s, eSum, eC, eV, eZ);
    tick();
    checkOutput({tag, ".doneOneCycle"}, 32'(done), 32'd0);
    checkOutput({tag, ".idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".holdSum"}, 32'(Sum), 32'(eSum));
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    applyStimulus(a, b, s);
    finishOp(tag, a, b, s, 1'b0);
    idleAfter(tag, a, b, s);
  endtask

  // Main sequence.
  initial begin
    logic [W-1:0] ra, rb, pa, pb, pSum;
    logic         rs, ps, pC, pV, pZ;
    assertCount = 0;
    failCount   = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.Sum", 32'(Sum), 32'd0);
    checkOutput("reset.flags", {29'd0, Cout, Ovfl, Zero}, 32'd0);
    rst = 1'b0;
    tick();

    runOp("add1234", 16'h1234, 16'h4321, 1'b0);
    runOp("addOvfl", 16'h7FFF, 16'h0001, 1'b0);
    runOp("addWrap", 16'hFFFF, 16'h0001, 1'b0);
    runOp("subZero", 16'h0005, 16'h0005, 1'b1);
    runOp("subOvfl", 16'h8000, 16'h0001, 1'b1);
    runOp("subBorrow", 16'h0003, 16'h0005, 1'b1);

    // start pulses during RUN must be ignored with no queued operation.
    applyStimulus(16'hA5A5, 16'h0F0F, 1'b0);
    finishOp("ignoreStart", 16'hA5A5, 16'h0F0F, 1'b0, 1'b1);
    idleAfter("ignoreStart", 16'hA5A5, 16'h0F0F, 1'b0);
    tick();
    checkOutput("ignoreStart.noQueue", 32'(busy), 32'd0);

    // Back-to-back: start held in DONE; first result holds into next RUN.
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    finishOp("b2bFirst", 16'h1111, 16'h2222, 1'b0, 1'b0);
    applyStimulus(16'h9000, 16'h1000, 1'b1);
    checkOutput("b2b.holdSum", 32'(Sum), 32'h3333);
    checkOutput("b2b.doneLow", 32'(done), 32'd0);
    finishOp("b2bSecond", 16'h9000, 16'h1000, 1'b1, 1'b0);
    idleAfter("b2bSecond", 16'h9000, 16'h1000, 1'b1);

    // Reset in the second RUN cycle aborts the operation.
    applyStimulus(16'h4444, 16'h5555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.Sum", 32'(Sum), 32'd0);
    checkOutput("abort.flags", {29'd0, Cout, Ovfl, Zero}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort.noDone", 32'(done), 32'd0);
    end
    runOp("afterAbort", 16'hBEEF, 16'h1234, 1'b1);

    // Randomized operations, sometimes chained back-to-back from DONE.
    pa = 16'hBEEF;
    pb = 16'h1234;
    ps = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h8000 ^ W'($urandom_range(0, 3));
        1:       ra = 16'h7FFF ^ W'($urandom_range(0, 3));
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(ra, rb, rs);
        refModel(pa, pb, ps, pSum, pC, pV, pZ);
        checkOutput("rand.b2bHold", 32'(Sum), 32'(pSum));
      end else begin
        tick();
        applyStimulus(ra, rb, rs);
      end
      finishOp("rand", ra, rb, rs, 1'($urandom));
      pa = ra;
      pb = rb;
      ps = rs;
    end
    idleAfter("randLast", pa, pb, ps);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
